// File: rtl/pp_vec_sched_pkg.sv
// Shared definitions for the ping-pong vector scheduler: bank-state encoding,
// default sizing and the Q7.8 sample width.
package softmax_pkg;

    typedef enum logic [1:0] {
        BK_EMPTY    = 2'd0,
        BK_FILLING  = 2'd1,
        BK_FULL     = 2'd2,
        BK_DRAINING = 2'd3
    } bank_state_t;

    localparam int C_MAX_DEF  = 1024;
    localparam int ADDR_W_DEF = 10;
    localparam int Q78_W      = 16;

endpackage

// File: rtl/pp_vec_sched_if.sv
// Sample write and drain handshakes of the ping-pong scheduler.
// The sample data and buffer read data bypass the scheduler entirely.
interface pp_vec_sched_if;

    logic in_valid;
    logic in_ready;
    logic in_last;
    logic out_valid;
    logic out_ready;
    logic out_last;

    modport master (
        output in_valid, in_last, out_ready,
        input  in_ready, out_valid, out_last
    );

    modport slave (
        input  in_valid, in_last, out_ready,
        output in_ready, out_valid, out_last
    );

endinterface

// File: rtl/pp_vec_sched_bank_state.sv
// Lifecycle of one buffer bank: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
// One-cycle state update; the bank never refuses an event, the top gates them.
module pp_bank_state
    import softmax_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr,
    input  logic        close,
    input  logic        rd_start,
    input  logic        rd_done,
    output bank_state_t state
);

    bank_state_t nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BK_EMPTY;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            BK_EMPTY: begin
                // A single-sample vector goes straight to FULL.
                if (close) begin
                    nxt = BK_FULL;
                end else if (wr) begin
                    nxt = BK_FILLING;
                end
            end
            BK_FILLING:  if (close)    nxt = BK_FULL;
            BK_FULL:     if (rd_start) nxt = BK_DRAINING;
            BK_DRAINING: if (rd_done)  nxt = BK_EMPTY;
            default:                   nxt = BK_EMPTY;
        endcase
    end

endmodule

// File: rtl/pp_vec_sched.sv
// Ping-pong vector write/drain scheduler; out_valid follows a FULL bank by one cycle (RAM prefetch).
// in_ready drops when both banks hold vectors; overflow clamp enabled by PP_VEC_SCHED_OVF_EN.
module pp_vec_sched
    import softmax_pkg::*;
#(
    parameter int C_MAX  = C_MAX_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    pp_vec_sched_if.slave     hs,
    output logic              buf_we,
    output logic              buf_wbank,
    output logic [ADDR_W-1:0] buf_waddr,
    output logic              buf_rbank,
    output logic [ADDR_W-1:0] buf_raddr,
    output logic              wr_done,
    output logic              wr_done_bank,
    output logic              rd_bank,
    output logic [ADDR_W:0]   len0,
    output logic [ADDR_W:0]   len1,
    output logic              err_ovf
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(C_MAX - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);

    bank_state_t       st [2];
    logic [ADDR_W:0]   len_q [2];
    logic              wb, rb, out_vld, dropping, ovf_flag;
    logic [ADDR_W-1:0] wcount, ridx, raddr_nxt;
    logic [ADDR_W:0]   cur_len;
    logic              in_rdy, wr_fire, wr_acc, wr_close, at_cap, ovf_hit;
    logic              rd_fire, rd_done, rd_start, last_beat;

    always_comb begin
        in_rdy    = (st[wb] == BK_EMPTY) || (st[wb] == BK_FILLING) || dropping;
        wr_fire   = hs.in_valid && in_rdy;
        wr_acc    = wr_fire && !dropping;
        at_cap    = (wcount == LAST_IDX);
        ovf_hit   = 1'b0;
`ifdef PP_VEC_SCHED_OVF_EN
        ovf_hit   = wr_acc && !hs.in_last && at_cap;
`endif
        wr_close  = wr_acc && (hs.in_last || ovf_hit);
        cur_len   = len_q[rb];
        rd_fire   = out_vld && hs.out_ready;
        last_beat = out_vld && ({1'b0, ridx} == cur_len - LEN_ONE);
        rd_done   = rd_fire && last_beat;
        rd_start  = !out_vld && (st[rb] == BK_FULL);
        // Address for the beat after this one, so rdata lines up under stalls.
        raddr_nxt = rd_fire ? ridx + IDX_ONE : ridx;
    end

    for (genvar i = 0; i < 2; i++) begin : g_bank
        pp_bank_state u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr       (wr_acc   && (wb == 1'(i))),
            .close    (wr_close && (wb == 1'(i))),
            .rd_start (rd_start && (rb == 1'(i))),
            .rd_done  (rd_done  && (rb == 1'(i))),
            .state    (st[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb           <= 1'b0;
            wcount       <= '0;
            len_q[0]     <= '0;
            len_q[1]     <= '0;
            wr_done      <= 1'b0;
            wr_done_bank <= 1'b0;
        end else begin
            wr_done <= wr_close;
            if (wr_acc) begin
                wcount <= (wr_close || at_cap) ? '0 : wcount + IDX_ONE;
            end
            if (wr_close) begin
                len_q[wb]    <= {1'b0, wcount} + LEN_ONE;
                wb           <= ~wb;
                wr_done_bank <= wb;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb      <= 1'b0;
            out_vld <= 1'b0;
            ridx    <= '0;
        end else if (rd_start) begin
            out_vld <= 1'b1;
        end else if (rd_done) begin
            out_vld <= 1'b0;
            rb      <= ~rb;
            ridx    <= '0;
        end else if (rd_fire) begin
            ridx    <= ridx + IDX_ONE;
        end
    end

`ifdef PP_VEC_SCHED_OVF_EN
    // After a forced close, swallow the tail of the oversize vector up to its real last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropping <= 1'b0;
            ovf_flag <= 1'b0;
        end else if (ovf_hit) begin
            dropping <= 1'b1;
            ovf_flag <= 1'b1;
        end else if (dropping && wr_fire && hs.in_last) begin
            dropping <= 1'b0;
        end
    end
`else
    assign dropping = 1'b0;
    assign ovf_flag = 1'b0;
`endif

    assign hs.in_ready  = in_rdy;
    assign hs.out_valid = out_vld;
    assign hs.out_last  = last_beat;
    assign buf_we       = wr_acc;
    assign buf_wbank    = wb;
    assign buf_waddr    = wcount;
    assign buf_rbank    = rb;
    assign buf_raddr    = raddr_nxt;
    assign rd_bank      = rb;
    assign len0         = len_q[0];
    assign len1         = len_q[1];
    assign err_ovf      = ovf_flag;

endmodule

// File: tb/tb_pp_vec_sched.sv
// Bench for pp_vec_sched: cycle table for a single vector, directed corner sequences,
// and randomized traffic scored against a vector-queue model plus a behavioural buffer RAM.
module tb_pp_vec_sched;
    import softmax_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pp_vec_sched_if vif();
    logic        buf_we, buf_wbank, buf_rbank, wr_done, wr_done_bank, rd_bank, err_ovf;
    logic [9:0]  buf_waddr, buf_raddr;
    logic [10:0] len0, len1;

    pp_vec_sched dut (
        .clk(clk), .rst_n(rst_n), .hs(vif),
        .buf_we(buf_we), .buf_wbank(buf_wbank), .buf_waddr(buf_waddr),
        .buf_rbank(buf_rbank), .buf_raddr(buf_raddr),
        .wr_done(wr_done), .wr_done_bank(wr_done_bank), .rd_bank(rd_bank),
        .len0(len0), .len1(len1), .err_ovf(err_ovf)
    );

`ifdef PP_VEC_SCHED_OVF_EN
    pp_vec_sched_if oif();
    logic       o_we, o_wbank, o_rbank, o_wrd, o_wrdb, o_rdb, o_err;
    logic [1:0] o_waddr, o_raddr;
    logic [2:0] o_len0, o_len1;
    pp_vec_sched #(.C_MAX(4), .ADDR_W(2)) dut_ovf (
        .clk(clk), .rst_n(rst_n), .hs(oif),
        .buf_we(o_we), .buf_wbank(o_wbank), .buf_waddr(o_waddr),
        .buf_rbank(o_rbank), .buf_raddr(o_raddr),
        .wr_done(o_wrd), .wr_done_bank(o_wrdb), .rd_bank(o_rdb),
        .len0(o_len0), .len1(o_len1), .err_ovf(o_err)
    );
`endif

    // Behavioural buffer RAM with one-cycle synchronous read.
    logic [Q78_W-1:0] mem [2][1024];
    logic [Q78_W-1:0] rdata, in_dat;

    int checks = 0;
    int failures = 0;

    // Model: one queue entry per accepted sample, drained strictly in arrival order.
    typedef struct { bit bank; int idx; bit last; logic [Q78_W-1:0] dat; } beat_t;
    beat_t exp_q[$];
    int pending;
    bit m_wb, prev_close, prev_close_bank;
    int m_wcnt;

    typedef struct packed {
        bit iv; bit il; bit ordy;
        bit rdy; bit we; bit [3:0] waddr; bit wrd; bit ov; bit ol; bit [3:0] raddr;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pending = 0;
        m_wb = 1'b0;
        m_wcnt = 0;
        prev_close = 1'b0;
        prev_close_bank = 1'b0;
    endtask

    task automatic monitor();
        beat_t b;
        chk("in_ready", 64'(vif.in_ready), 64'(pending < 2));
        chk("wr_done", 64'(wr_done), 64'(prev_close));
        if (prev_close) chk("wr_done_bank", 64'(wr_done_bank), 64'(prev_close_bank));
        prev_close = 1'b0;
        if (vif.in_valid && vif.in_ready) begin
            chk("buf_we", 64'(buf_we), 64'(1));
            chk("buf_wbank", 64'(buf_wbank), 64'(m_wb));
            chk("buf_waddr", 64'(buf_waddr), 64'(m_wcnt));
            exp_q.push_back('{m_wb, m_wcnt, vif.in_last, in_dat});
            if (vif.in_last) begin
                prev_close = 1'b1;
                prev_close_bank = m_wb;
                pending++;
                m_wb = ~m_wb;
                m_wcnt = 0;
            end else begin
                m_wcnt++;
            end
        end else begin
            chk("buf_we_idle", 64'(buf_we), 64'(0));
        end
        if (vif.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_valid_unexpected: got 1 expected 0 at %0t", $time);
            end else begin
                b = exp_q[0];
                chk("rbank", 64'(buf_rbank), 64'(b.bank));
                chk("out_last", 64'(vif.out_last), 64'(b.last));
                chk("raddr", 64'(buf_raddr), 64'(vif.out_ready ? b.idx + 1 : b.idx));
                if (vif.out_ready) begin
                    chk("rdata", 64'(rdata), 64'(b.dat));
                    void'(exp_q.pop_front());
                    if (b.last) pending--;
                end
            end
        end
        if (buf_we) mem[buf_wbank][buf_waddr] = in_dat;
        rdata = mem[buf_rbank][buf_raddr];
    endtask

    task automatic step(input bit iv, input bit il, input bit ordy);
        @(negedge clk);
        vif.in_valid = iv;
        vif.in_last = il;
        vif.out_ready = ordy;
        in_dat = 16'($urandom);
        #1;
        monitor();
    endtask

    task automatic send_vec(input int n, input bit ordy);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 200) begin
            step(1'b1, i == n - 1, ordy);
            if (vif.in_ready) i++;
            guard++;
        end
        chk("send_done", 64'(i), 64'(n));
    endtask

    // mode 0: ready held high, 1: ready toggles 1010, 2: random ready
    task automatic drain(input int budget, input int mode, output int beats, output int bubbles);
        bit ordy;
        bit started = 1'b0;
        beats = 0;
        bubbles = 0;
        for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
            ordy = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : ($urandom_range(0, 1) == 1);
            step(1'b0, 1'b0, ordy);
            if (vif.out_valid) started = 1'b1;
            if (vif.out_valid && ordy) beats++;
            else if (!vif.out_valid && started) bubbles++;
        end
        chk("drain_done", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic chk_reset_vals();
        logic [38:0] act, exp;
        act = {vif.in_ready, buf_we, vif.out_valid, vif.out_last, wr_done, err_ovf, rd_bank,
               buf_raddr, len0, len1};
        exp = {1'b1, 38'd0};
        chk("reset_vals", 64'(act), 64'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        int beats, bubbles, rem;
        bit iv, lb;
        logic [13:0] act, exp;

        tbl[0] = '{1'b1,1'b0,1'b1, 1'b1,1'b1,4'd0,1'b0,1'b0,1'b0,4'd0};
        tbl[1] = '{1'b1,1'b0,1'b1, 1'b1,1'b1,4'd1,1'b0,1'b0,1'b0,4'd0};
        tbl[2] = '{1'b1,1'b0,1'b1, 1'b1,1'b1,4'd2,1'b0,1'b0,1'b0,4'd0};
        tbl[3] = '{1'b1,1'b1,1'b1, 1'b1,1'b1,4'd3,1'b0,1'b0,1'b0,4'd0};
        tbl[4] = '{1'b0,1'b0,1'b1, 1'b1,1'b0,4'd0,1'b1,1'b0,1'b0,4'd0};
        tbl[5] = '{1'b0,1'b0,1'b1, 1'b1,1'b0,4'd0,1'b0,1'b1,1'b0,4'd1};
        tbl[6] = '{1'b0,1'b0,1'b1, 1'b1,1'b0,4'd0,1'b0,1'b1,1'b0,4'd2};
        tbl[7] = '{1'b0,1'b0,1'b1, 1'b1,1'b0,4'd0,1'b0,1'b1,1'b0,4'd3};
        tbl[8] = '{1'b0,1'b0,1'b1, 1'b1,1'b0,4'd0,1'b0,1'b1,1'b1,4'd4};
        tbl[9] = '{1'b0,1'b0,1'b1, 1'b1,1'b0,4'd0,1'b0,1'b0,1'b0,4'd0};

        vif.in_valid = 1'b0;
        vif.in_last = 1'b0;
        vif.out_ready = 1'b0;
        in_dat = '0;
        rdata = '0;
`ifdef PP_VEC_SCHED_OVF_EN
        oif.in_valid = 1'b0;
        oif.in_last = 1'b0;
        oif.out_ready = 1'b0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk_reset_vals();
        chk("err_ovf_default", 64'(err_ovf), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single 4-sample vector with a free-running consumer, checked cycle by cycle.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].iv, tbl[i].il, tbl[i].ordy);
            act = {vif.in_ready, buf_we, buf_we ? buf_waddr[3:0] : 4'd0, wr_done,
                   vif.out_valid, vif.out_last, buf_raddr[3:0]};
            exp = {tbl[i].rdy, tbl[i].we, tbl[i].waddr, tbl[i].wrd, tbl[i].ov, tbl[i].ol,
                   tbl[i].raddr};
            chk($sformatf("vec%0d", i), 64'(act), 64'(exp));
        end
        chk("len0_4", 64'(len0), 64'(4));
        chk("rd_bank_after", 64'(rd_bank), 64'(1));

        // One-sample vector lands in bank 1 and drains as a single last beat.
        send_vec(1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("len1_1", 64'(len1), 64'(1));
        drain(20, 0, beats, bubbles);
        chk("len1_beats", 64'(beats), 64'(1));

        // Two 8-sample vectors against a stalled consumer: both banks occupied.
        send_vec(8, 1'b0);
        send_vec(8, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("both_full_in_ready", 64'(vif.in_ready), 64'(0));
        chk("stalled_out_valid", 64'(vif.out_valid), 64'(1));
        drain(60, 0, beats, bubbles);
        chk("b2b_beats", 64'(beats), 64'(16));
        chk("b2b_bubbles", 64'(bubbles), 64'(1));

        // Alternating ready during a drain.
        send_vec(8, 1'b0);
        drain(60, 1, beats, bubbles);
        chk("toggle_beats", 64'(beats), 64'(8));

        // Randomized traffic.
        rem = 0;
        for (int c = 0; c < 1500; c++) begin
            if (rem == 0) rem = $urandom_range(1, 12);
            iv = ($urandom_range(0, 9) < 7);
            lb = (rem == 1);
            step(iv, lb, $urandom_range(0, 9) < 6);
            if (iv && vif.in_ready) rem--;
        end
        for (int g = 0; g < 100 && rem > 0; g++) begin
            step(1'b1, rem == 1, 1'b1);
            if (vif.in_ready) rem--;
        end
        drain(400, 2, beats, bubbles);
        chk("rand_pending", 64'(pending), 64'(0));

        // Reset in the middle of draining an 8-sample vector.
        send_vec(8, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        vif.in_valid = 1'b0;
        vif.in_last = 1'b0;
        vif.out_ready = 1'b0;
        #1;
        chk_reset_vals();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("post_reset_quiet", 64'({vif.out_valid, wr_done}), 64'(0));
        end
        send_vec(2, 1'b1);
        drain(20, 0, beats, bubbles);
        chk("post_reset_beats", 64'(beats), 64'(2));
        chk("post_reset_len0", 64'(len0), 64'(2));

`ifdef PP_VEC_SCHED_OVF_EN
        // Six samples into a 4-deep bank, the sixth carrying in_last.
        for (int s = 1; s <= 6; s++) begin
            @(negedge clk);
            oif.in_valid = 1'b1;
            oif.in_last = (s == 6);
            #1;
            chk($sformatf("ovf_we%0d", s), 64'(o_we), 64'(s <= 4));
            chk($sformatf("ovf_rdy%0d", s), 64'(oif.in_ready), 64'(1));
        end
        @(negedge clk);
        oif.in_valid = 1'b0;
        oif.in_last = 1'b0;
        #1;
        chk("ovf_len0", 64'(o_len0), 64'(4));
        chk("ovf_len1", 64'(o_len1), 64'(0));
        chk("ovf_err", 64'(o_err), 64'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pp_vec_sched.md
PP_VEC_SCHED -- requirements
Module: pp_vec_sched

Interface
REQ-001 Parameter C_MAX, default 1024, max samples per vector (per bank).
REQ-002 Parameter ADDR_W, default 10, buffer address width; C_MAX SHALL be at most 2**ADDR_W.
REQ-003 clk  in  1  clock, all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid / in_ready / in_last  in/out/in  1 each  Q7.8 sample write handshake (data bypasses block straight to buffer).
REQ-006 buf_we  out  1; buf_wbank  out  1; buf_waddr  out  ADDR_W  ping-pong buffer write port.
REQ-007 buf_rbank  out  1; buf_raddr  out  ADDR_W  synchronous-read port (1-cycle RAM latency).
REQ-008 out_valid / out_ready / out_last  out/in/out  1 each  drain handshake aligned with buffer rdata.
REQ-009 wr_done  out  1; wr_done_bank  out  1  pulse at vector close; downstream latches Xmax for that bank.
REQ-010 rd_bank  out  1  bank being drained; selects per-bank Xmax for the subtractor.
REQ-011 len0, len1  out  ADDR_W+1  stored vector length per bank.
REQ-012 err_ovf  out  1  sticky overflow flag (macro-dependent, see Configuration).

Function
REQ-013 Each bank SHALL hold state EMPTY, FILLING, FULL or DRAINING; write pointer wb and read pointer rb each 1 bit.
REQ-014 in_ready SHALL be 1 iff bank wb is EMPTY or FILLING; write fire = in_valid & in_ready.
REQ-015 On write fire: buf_we=1 combinationally, buf_wbank=wb, buf_waddr=write count; bank wb EMPTY->FILLING; count increments.
REQ-016 On write fire with in_last: len[wb]<=count+1, bank wb->FULL, wb toggles, count<=0, wr_done pulses one cycle later with wr_done_bank=old wb.
REQ-017 Drain: when bank rb is FULL and not yet draining, it SHALL go DRAINING and out_valid SHALL rise on the following cycle (1-cycle RAM prefetch), raddr issued as 0.
REQ-018 buf_raddr SHALL be combinational next-address: read index+1 on fire (out_valid & out_ready), else held index, so rdata matches out_valid data under stall.
REQ-019 out_last SHALL be 1 when read index == len[rb]-1 and out_valid.
REQ-020 On fire with out_last: bank rb->EMPTY, rb toggles, out_valid drops unless the other bank is FULL, in which case it SHALL start next cycle (1 bubble maximum).
REQ-021 out_valid SHALL stay asserted and out_last/buf_raddr stable while out_ready=0.
REQ-022 Filling one bank and draining the other SHALL proceed concurrently; both banks FULL SHALL deassert in_ready.
REQ-023 Zero-length vectors impossible: in_last on first sample gives len=1 and a one-beat drain.
REQ-024 Simultaneous drain completion of bank X and write fire into bank X is impossible by REQ-014; completion and write on the other bank SHALL both take effect.

Reset
REQ-025 On rst_n low: both banks EMPTY, wb=rb=0, counts/lens 0, in_ready=1, buf_we=0, out_valid=0, out_last=0, wr_done=0, err_ovf=0, buf_raddr=0.
REQ-026 Reset mid-vector SHALL discard partial and stored vectors; no wr_done or out_valid after release until new input.

Configuration
REQ-027 Macro PP_VEC_SCHED_OVF_EN: defined -> write fire at count==C_MAX-1 without in_last SHALL force vector close as if in_last, set err_ovf sticky; further samples up to real in_last SHALL be accepted and dropped (buf_we=0).
REQ-028 Undefined -> no overflow logic, err_ovf tied 0, count wraps; caller guarantees vector <= C_MAX.

Structure
REQ-029 Shared package softmax_pkg SHALL hold bank-state encoding, C_MAX/ADDR_W defaults and Q7.8 width constant.
REQ-030 One sub-module pp_bank_state (per-bank 4-state FSM), instantiated twice.

Verification
REQ-031 Single 4-sample vector, out_ready=1 -> wr_done after 4th sample, out_valid 4 beats raddr 0..3, out_last on beat 4, len0=4.
REQ-032 Back-to-back 8-sample vectors, out_ready=0 -> both banks FULL, in_ready=0 after sample 16; release out_ready -> 16 beats, one bubble between vectors.
REQ-033 out_ready toggling 1010 during drain -> raddr held on stall cycles, no duplicated or lost index.
REQ-034 Overflow (macro on, C_MAX=4): 6 samples then in_last -> len0=4, err_ovf=1, samples 5-6 buf_we=0.
REQ-035 Reset asserted mid-drain of 8-sample vector -> all outputs reset values next edge; fresh 2-sample vector drains correctly from bank 0.
